alarm_clock_ctrl: RTL and testbench



---
 rtl/alarm_clock_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: keeps current/alarm time, handles set modes and ringing.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_clock_ctrl #(
  parameter int unsigned TICK_DIV     = 4,
  parameter int unsigned TIME_MAX     = 15,
  parameter int unsigned RING_TICKS   = 8,
  parameter int unsigned SNOOZE_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc,
  input  logic       show_btn,
  input  logic       alarm_en,
  input  logic       alarm_off,
  input  logic       snooze,
  output logic [3:0] current_time,
  output logic [3:0] alarm_time,
  output logic       show_a,
  output logic       sound_alarm,
  output logic [1:0] mode,
  output logic       snoozing
);

  localparam int unsigned TIME_W = 4;
  localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RING_W = $clog2(RING_TICKS + 1);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10,
    RINGING   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [TIME_W-1:0]   alarm_q, alarm_d;
  logic [RING_W-1:0]   ring_q, ring_d;
  logic                show_a_q, show_a_d;
  logic                sound_q, sound_d;

  logic                tick_c;
  logic                ring_start_c;
  logic [TIME_W-1:0]   next_time_c;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_W = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS + 1) : 1;
  logic                snoozing_q, snoozing_d;
  logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
`else
  logic                unused_snooze_c;
  assign unused_snooze_c = snooze & (SNOOZE_TICKS != 0);
`endif

  // Increment a 4-bit time value with wrap after TIME_MAX.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v);
    return (v == TIME_W'(TIME_MAX)) ? '0 : v + TIME_W'(1);
  endfunction

  // Next-state, prescaler and time/alarm update.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    time_d       = time_q;
    alarm_d      = alarm_q;
    ring_d       = ring_q;
    ring_start_c = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snoozing_d   = snoozing_q;
    snz_cnt_d    = snz_cnt_q;
`endif

    tick_c      = (state_q != SET_TIME) && (pre_q == PRE_W'(TICK_DIV - 1));
    next_time_c = wrap_inc(time_q);

    // Prescaler frozen at 0 while setting time, so it restarts cleanly on exit.
    if (state_q == SET_TIME || tick_c) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    if (tick_c) begin
      time_d = next_time_c;
    end

    unique case (state_q)
      RUN: begin
        if (set_time) begin
          state_d = SET_TIME;
`ifdef ALARM_SNOOZE_EN
          snoozing_d = 1'b0;
`endif
        end else if (set_alarm) begin
          state_d = SET_ALARM;
`ifdef ALARM_SNOOZE_EN
          snoozing_d = 1'b0;
`endif
        end else begin
          if (tick_c && alarm_en && (next_time_c == alarm_q)) begin
            ring_start_c = 1'b1;
          end
`ifdef ALARM_SNOOZE_EN
          if (!alarm_en) begin
            snoozing_d = 1'b0;
          end else if (snoozing_q && tick_c) begin
            if (snz_cnt_q == SNZ_W'(1)) begin
              snoozing_d   = 1'b0;
              snz_cnt_d    = '0;
              ring_start_c = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q - SNZ_W'(1);
            end
          end
`endif
          if (ring_start_c) begin
            state_d = RINGING;
            ring_d  = '0;
          end
        end
      end

      SET_TIME: begin
        if (set_time) begin
          state_d = RUN;
        end else if (inc) begin
          time_d = next_time_c;
        end
      end

      SET_ALARM: begin
        if (set_alarm) begin
          state_d = RUN;
        end else if (inc) begin
          alarm_d = wrap_inc(alarm_q);
        end
      end

      RINGING: begin
        if (alarm_off || !alarm_en) begin
          state_d = RUN;
`ifdef ALARM_SNOOZE_EN
          snoozing_d = 1'b0;
        end else if (snooze) begin
          state_d    = RUN;
          snoozing_d = 1'b1;
          snz_cnt_d  = SNZ_W'(SNOOZE_TICKS);
`endif
        end else if (tick_c) begin
          ring_d = ring_q + RING_W'(1);
          if (ring_q + RING_W'(1) == RING_W'(RING_TICKS)) begin
            state_d = RUN;
          end
        end
      end
    endcase

    show_a_d = (state_d == SET_ALARM) || ((state_d == RUN) && show_btn);
    sound_d  = (state_d == RINGING);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pre_q      <= '0;
      time_q     <= '0;
      alarm_q    <= '0;
      ring_q     <= '0;
      show_a_q   <= 1'b0;
      sound_q    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snoozing_q <= 1'b0;
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      time_q     <= time_d;
      alarm_q    <= alarm_d;
      ring_q     <= ring_d;
      show_a_q   <= show_a_d;
      sound_q    <= sound_d;
`ifdef ALARM_SNOOZE_EN
      snoozing_q <= snoozing_d;
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  assign current_time = time_q;
  assign alarm_time   = alarm_q;
  assign show_a       = show_a_q;
  assign sound_alarm  = sound_q;
  assign mode         = state_q;
`ifdef ALARM_SNOOZE_EN
  assign snoozing     = snoozing_q;
`else
  assign snoozing     = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_alarm_clock_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int TIME_MAX     = 15;
  localparam int RING_TICKS   = 8;
  localparam int SNOOZE_TICKS = 3;
  localparam int TIME_MOD     = TIME_MAX + 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       set_time = 1'b0, set_alarm = 1'b0, inc = 1'b0, show_btn = 1'b0;
  logic       alarm_en = 1'b0, alarm_off = 1'b0, snooze = 1'b0;
  logic [3:0] current_time, alarm_time;
  logic       show_a, sound_alarm, snoozing;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  // Reference model state (mode: 0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 RINGING)
  int m_mode, m_time, m_alarm, m_pre, m_ring, m_snz, m_scnt, m_show, m_sound;

  alarm_clock_ctrl #(
    .TICK_DIV(TICK_DIV), .TIME_MAX(TIME_MAX),
    .RING_TICKS(RING_TICKS), .SNOOZE_TICKS(SNOOZE_TICKS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .set_time(set_time), .set_alarm(set_alarm),
    .inc(inc), .show_btn(show_btn), .alarm_en(alarm_en), .alarm_off(alarm_off),
    .snooze(snooze), .current_time(current_time), .alarm_time(alarm_time),
    .show_a(show_a), .sound_alarm(sound_alarm), .mode(mode), .snoozing(snoozing)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_time = 0; m_alarm = 0; m_pre = 0; m_ring = 0;
    m_snz = 0; m_scnt = 0; m_show = 0; m_sound = 0;
  endtask

  // One clock of behaviour, computed from the current inputs.
  task automatic model_step();
    int  n_mode, n_time, n_alarm, n_pre, n_ring, n_snz, n_scnt;
    bit  tick, ring;
    tick    = (m_mode != 1) && (m_pre == TICK_DIV - 1);
    n_pre   = (m_mode == 1) ? 0 : (m_pre + 1) % TICK_DIV;
    n_time  = tick ? (m_time + 1) % TIME_MOD : m_time;
    n_mode  = m_mode; n_alarm = m_alarm; n_ring = m_ring;
    n_snz   = m_snz;  n_scnt  = m_scnt;
    ring    = 0;
    case (m_mode)
      0: begin
        if (set_time)       begin n_mode = 1; n_snz = 0; end
        else if (set_alarm) begin n_mode = 2; n_snz = 0; end
        else begin
          ring = tick && alarm_en && (n_time == m_alarm);
`ifdef ALARM_SNOOZE_EN
          if (!alarm_en) n_snz = 0;
          else if (m_snz != 0 && tick) begin
            n_scnt = m_scnt - 1;
            if (n_scnt == 0) begin n_snz = 0; ring = 1; end
          end
`endif
          if (ring) begin n_mode = 3; n_ring = 0; end
        end
      end
      1: if (set_time) n_mode = 0; else if (inc) n_time = (m_time + 1) % TIME_MOD;
      2: if (set_alarm) n_mode = 0; else if (inc) n_alarm = (m_alarm + 1) % TIME_MOD;
      default: begin
        if (alarm_off || !alarm_en) begin n_mode = 0; n_snz = 0; end
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin n_mode = 0; n_snz = 1; n_scnt = SNOOZE_TICKS; end
`endif
        else if (tick) begin
          n_ring = m_ring + 1;
          if (n_ring >= RING_TICKS) n_mode = 0;
        end
      end
    endcase
    m_mode = n_mode; m_time = n_time; m_alarm = n_alarm; m_pre = n_pre;
    m_ring = n_ring; m_snz = n_snz; m_scnt = n_scnt;
    m_show  = ((m_mode == 2) || (m_mode == 0 && show_btn)) ? 1 : 0;
    m_sound = (m_mode == 3) ? 1 : 0;
  endtask

  task automatic check_all();
    check("current_time", 32'(current_time), 32'(m_time));
    check("alarm_time",   32'(alarm_time),   32'(m_alarm));
    check("mode",         32'(mode),         32'(m_mode));
    check("show_a",       32'(show_a),       32'(m_show));
    check("sound_alarm",  32'(sound_alarm),  32'(m_sound));
    check("snoozing",     32'(snoozing),     32'(m_snz));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check_all();
    set_time = 0; set_alarm = 0; inc = 0; alarm_off = 0; snooze = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_time_to(input int v);
    int n;
    set_time = 1; cycle();
    n = (v - m_time + TIME_MOD) % TIME_MOD;
    for (int i = 0; i < n; i++) begin inc = 1; cycle(); end
    set_time = 1; cycle();
  endtask

  task automatic set_alarm_to(input int v);
    int n;
    set_alarm = 1; cycle();
    n = (v - m_alarm + TIME_MOD) % TIME_MOD;
    for (int i = 0; i < n; i++) begin inc = 1; cycle(); end
    set_alarm = 1; cycle();
  endtask

  // Asynchronous reset taken away from the clock edge; outputs must clear at once.
  task automatic async_reset();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_all();
    check("reset_time_zero", 32'(current_time), 32'd0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 0;
    #1;
    check_all();
    @(negedge clock);
    reset_n = 1;

    // Free running time
    cycles(20);
    check("tp_run_time5", 32'(current_time), 32'd5);
    check("tp_run_mode", 32'(mode), 32'd0);
    cycles(2);
    async_reset();

    // Set time to 3 and watch the restart of the prescaler
    set_time = 1; cycle();
    for (int i = 0; i < 3; i++) begin inc = 1; cycle(); end
    set_time = 1; cycle();
    check("tp_set_time3", 32'(current_time), 32'd3);
    cycles(3);
    check("tp_hold_time3", 32'(current_time), 32'd3);
    cycle();
    check("tp_after_tick4", 32'(current_time), 32'd4);

    // Alarm at 4, time at 3, armed: next tick rings
    alarm_en = 1;
    set_alarm = 1; cycle();
    check("tp_show_a_set", 32'(show_a), 32'd1);
    for (int i = 0; i < 4; i++) begin inc = 1; cycle(); end
    check("tp_alarm4", 32'(alarm_time), 32'd4);
    set_alarm = 1; cycle();
    check("tp_show_a_exit", 32'(show_a), 32'd0);
    set_time_to(3);
    cycles(4);
    check("tp_ring_time4", 32'(current_time), 32'd4);
    check("tp_ring_mode", 32'(mode), 32'd3);
    check("tp_ring_sound", 32'(sound_alarm), 32'd1);

    // Ring left alone stops after RING_TICKS ticks
    cycles(RING_TICKS * TICK_DIV - 1);
    check("tp_still_ringing", 32'(sound_alarm), 32'd1);
    cycle();
    check("tp_auto_stop_mode", 32'(mode), 32'd0);
    check("tp_auto_stop_sound", 32'(sound_alarm), 32'd0);

    // alarm_off on a tick cycle wins over the tick
    set_time_to(3);
    cycles(4);
    check("tp_ring2_mode", 32'(mode), 32'd3);
    cycles(3);
    alarm_off = 1; cycle();
    check("tp_off_mode", 32'(mode), 32'd0);
    check("tp_off_time5", 32'(current_time), 32'd5);

    // Alarm at 0 matches on wrap; disarmed does not
    set_alarm_to(0);
    set_time_to(15);
    cycles(4);
    check("tp_wrap_time0", 32'(current_time), 32'd0);
    check("tp_wrap_ring", 32'(mode), 32'd3);
    alarm_off = 1; cycle();
    alarm_en = 0;
    set_time_to(15);
    cycles(4);
    check("tp_dis_time0", 32'(current_time), 32'd0);
    check("tp_dis_no_ring", 32'(sound_alarm), 32'd0);
    alarm_en = 1;

    // Snooze
    set_time_to(15);
    cycles(4);
    check("tp_snz_ring", 32'(mode), 32'd3);
    snooze = 1; cycle();
`ifdef ALARM_SNOOZE_EN
    check("tp_snz_flag", 32'(snoozing), 32'd1);
    check("tp_snz_quiet", 32'(sound_alarm), 32'd0);
    cycles(SNOOZE_TICKS * TICK_DIV);
    check("tp_snz_reringing", 32'(sound_alarm), 32'd1);
    check("tp_snz_cleared", 32'(snoozing), 32'd0);
`else
    check("tp_snz_ignored", 32'(mode), 32'd3);
    check("tp_snz_tied", 32'(snoozing), 32'd0);
`endif
    alarm_off = 1; cycle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_time  = ($urandom_range(0, 199) < 3);
      set_alarm = ($urandom_range(0, 199) < 3);
      inc       = ($urandom_range(0, 99) < 25);
      alarm_off = ($urandom_range(0, 99) < 3);
      snooze    = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 10) show_btn = ~show_btn;
      if ($urandom_range(0, 99) < 3) alarm_en = ($urandom_range(0, 99) < 80);
      cycle();
      if (i == 1500) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
